// File: rtl/tft_spi_receiver.sv
// tft_spi_receiver: oversampling SPI word decoder with valid/ready FIFO; TFT_SPI_RX_STATUS_EN adds WordCount
module tft_spi_receiver #(
  parameter int WordBits  = 16,
  parameter int FifoDepth = 4
) (
  input  logic                MasterCLK,
  input  logic                nRST,
  input  logic                SPI_CLK,
  input  logic                SPI_MOSI,
  input  logic                SPI_CS,
  input  logic                RS,
  output logic [WordBits-1:0] OutData,
  output logic                OutRS,
  output logic                OutValid,
  input  logic                OutReady,
  output logic                Overflow,
  output logic                FrameErr
`ifdef TFT_SPI_RX_STATUS_EN
  ,
  output logic [15:0]         WordCount
`endif
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = $clog2(WordBits);
  localparam logic [CW-1:0] LastBit = CW'(WordBits - 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, stateNext;
  logic clkS1, clkS2, clkPrev, mosiS1, mosiS2, csS1, csS2, rsS1, rsS2;
  logic [1:0] warm;
  logic armed, rise, push, frameErrNext;
  logic [CW-1:0] cnt, cntNext;
  logic [WordBits-2:0] shiftReg, shiftNext;
  logic [WordBits-1:0] word;
  logic [WordBits:0] mem [FifoDepth];
  logic [AW:0] wrPtr, rdPtr;
  logic full, pop, wrEn;
  // Synchronizers; armed needs CS seen high on real samples, so a frame in flight at reset release is skipped
  always_ff @(posedge MasterCLK or negedge nRST)
    if (!nRST) begin
      {clkS1, clkS2, clkPrev, mosiS1, mosiS2, rsS1, rsS2} <= '0;
      {csS1, csS2} <= 2'b11;
      warm <= '0;
      armed <= 1'b0;
    end else begin
      {clkS1, clkS2, clkPrev} <= {SPI_CLK, clkS1, clkS2};
      {mosiS1, mosiS2} <= {SPI_MOSI, mosiS1};
      {csS1, csS2} <= {SPI_CS, csS1};
      {rsS1, rsS2} <= {RS, rsS1};
      warm <= {warm[0], 1'b1};
      armed <= armed | (warm[1] & csS2);
    end
  assign rise = clkS2 & ~clkPrev;
  assign word = {shiftReg, mosiS2};
  // FSM state, bit counter, shift register and frame error pulse
  always_ff @(posedge MasterCLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
      shiftReg <= '0;
      FrameErr <= 1'b0;
    end else begin
      state <= stateNext;
      cnt <= cntNext;
      shiftReg <= shiftNext;
      FrameErr <= frameErrNext;
    end
  // Next-state: shift on synced rise, push on last bit, abort on CS release
  always_comb begin
    stateNext = state;
    cntNext = cnt;
    shiftNext = shiftReg;
    push = 1'b0;
    frameErrNext = 1'b0;
    if (state == IDLE) begin
      cntNext = '0;
      if (armed && !csS2) stateNext = SHIFT;
    end else if (csS2) begin
      stateNext = IDLE;
      cntNext = '0;
      frameErrNext = cnt != '0;
    end else if (rise) begin
      shiftNext = word[WordBits-2:0];
      push = cnt == LastBit;
      cntNext = push ? '0 : cnt + 1'b1;
    end
  end
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign OutValid = wrPtr != rdPtr;
  assign pop = OutValid & OutReady;
  assign wrEn = push & (~full | pop);
  assign {OutRS, OutData} = OutValid ? mem[rdPtr[AW-1:0]] : '0;
  // FIFO pointers and sticky overflow on a dropped word
  always_ff @(posedge MasterCLK or negedge nRST)
    if (!nRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      Overflow <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      Overflow <= Overflow | (push & full & ~pop);
    end
  // FIFO storage; reads are masked while empty so no reset is needed
  always_ff @(posedge MasterCLK)
    if (wrEn) mem[wrPtr[AW-1:0]] <= {rsS2, word};
`ifdef TFT_SPI_RX_STATUS_EN
  // Accepted-word counter, wraps naturally
  always_ff @(posedge MasterCLK or negedge nRST)
    if (!nRST) WordCount <= '0;
    else if (wrEn) WordCount <= WordCount + 1'b1;
`endif
endmodule

// File: tb/tb_tft_spi_receiver.sv
// tb_tft_spi_receiver: randomized checks of tft_spi_receiver against a queue model
module tb_tft_spi_receiver;
  logic MasterCLK = 0, nRST = 1, SPI_CLK = 0, SPI_MOSI = 0, SPI_CS = 1, RS = 0, OutReady = 0;
  logic [15:0] OutData;
  logic OutRS, OutValid, Overflow, FrameErr;
`ifdef TFT_SPI_RX_STATUS_EN
  logic [15:0] WordCount;
`endif
  int tests = 0, fails = 0, accepted = 0;
  logic [16:0] q[$];
  logic [16:0] monExp;
  logic expOverflow = 0;
  bit randDone;

  tft_spi_receiver dut (
    .MasterCLK(MasterCLK), .nRST(nRST), .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI),
    .SPI_CS(SPI_CS), .RS(RS), .OutData(OutData), .OutRS(OutRS), .OutValid(OutValid),
    .OutReady(OutReady), .Overflow(Overflow), .FrameErr(FrameErr)
`ifdef TFT_SPI_RX_STATUS_EN
    , .WordCount(WordCount)
`endif
  );

  always #5 MasterCLK = ~MasterCLK;

  // Scoreboard: every accepted beat must match the model queue head
  always @(negedge MasterCLK)
    if (nRST && OutValid && OutReady) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL pop_unexpected got %h expected none", {OutRS, OutData});
      end else begin
        monExp = q.pop_front();
        if ({OutRS, OutData} !== monExp) begin
          fails++;
          $display("FAIL pop_data got %h expected %h", {OutRS, OutData}, monExp);
        end
      end
    end

  task tick; @(posedge MasterCLK); #1; endtask

  task spiBit(input logic b);
    SPI_MOSI = b; repeat (4) tick(); SPI_CLK = 1; repeat (4) tick(); SPI_CLK = 0;
  endtask

  task shiftBits(input logic [15:0] d, input int n);
    for (int i = 15; i > 15 - n; i--) spiBit(d[i]);
  endtask

  task expectWord(input logic [15:0] d, input logic r);
    if (q.size() < 4) begin q.push_back({r, d}); accepted++; end
    else expOverflow = 1;
  endtask

  task sendWord(input logic [15:0] d, input logic r);
    RS = r; shiftBits(d, 15);
    SPI_MOSI = d[0]; repeat (4) tick(); SPI_CLK = 1;
    expectWord(d, r);
    repeat (4) tick(); SPI_CLK = 0;
  endtask

  task csLow; SPI_CS = 0; repeat (4) tick(); endtask
  task csHigh; SPI_CLK = 0; SPI_CS = 1; repeat (6) tick(); endtask

  task doReset;
    nRST = 0; repeat (2) tick();
    q.delete(); expOverflow = 0; accepted = 0;
    nRST = 1; repeat (3) tick();
  endtask

  task drain(input string name);
    OutReady = 1;
    for (int i = 0; i < 60 && (q.size() != 0 || OutValid); i++) tick();
    tests++;
    if (q.size() != 0 || OutValid !== 0) begin
      fails++;
      $display("FAIL %s_drain got left=%0d valid=%b expected left=0 valid=0", name, q.size(), OutValid);
    end
    OutReady = 0;
  endtask

  task checkZero(input string name);
    tests++;
    if ({OutValid, OutData, OutRS, Overflow, FrameErr} !== '0) begin
      fails++;
      $display("FAIL %s got valid=%b data=%h rs=%b ovf=%b ferr=%b expected all 0", name, OutValid, OutData, OutRS, Overflow, FrameErr);
    end
  endtask

  task test_reset;
    #2 nRST = 0; #1 checkZero("reset_async");
    repeat (2) tick(); nRST = 1; repeat (3) tick();
    checkZero("reset_release");
  endtask

  task test_single;
    OutReady = 1; csLow(); RS = 1;
    shiftBits(16'hA55A, 15);
    SPI_MOSI = 0; repeat (4) tick(); SPI_CLK = 1;
    for (int e = 1; e <= 2; e++) begin
      tick(); tests++;
      if (OutValid !== 0) begin fails++; $display("FAIL latency_edge%0d got valid=%b expected 0", e, OutValid); end
    end
    expectWord(16'hA55A, 1);
    tick(); tests++;
    if ({OutValid, OutRS, OutData} !== {2'b11, 16'hA55A}) begin
      fails++; $display("FAIL latency_edge3 got valid=%b rs=%b data=%h expected 1 1 a55a", OutValid, OutRS, OutData);
    end
    repeat (2) tick(); SPI_CLK = 0; csHigh(); drain("single");
  endtask

  task test_hold;
    OutReady = 0; csLow();
    sendWord(16'h0011, 0); sendWord(16'h0029, 0); csHigh();
    for (int i = 0; i < 5; i++) begin
      tick(); tests++;
      if ({OutValid, OutRS, OutData} !== {2'b10, 16'h0011}) begin
        fails++; $display("FAIL hold got valid=%b rs=%b data=%h expected 1 0 0011", OutValid, OutRS, OutData);
      end
    end
    drain("hold");
  endtask

  task test_overflow;
    OutReady = 0; csLow();
    for (int i = 0; i < 5; i++) sendWord(16'($urandom), 1'($urandom));
    csHigh(); tests++;
    if (Overflow !== expOverflow || expOverflow !== 1) begin
      fails++; $display("FAIL overflow_set got %b expected %b", Overflow, expOverflow);
    end
    drain("overflow"); tests++;
    if (Overflow !== 1) begin fails++; $display("FAIL overflow_sticky got %b expected 1", Overflow); end
  endtask

  task test_coincide;
    logic [15:0] d;
    logic r;
    doReset(); OutReady = 0; csLow();
    for (int i = 0; i < 4; i++) sendWord(16'($urandom), 1'($urandom));
    d = 16'($urandom); r = 1'($urandom); RS = r;
    shiftBits(d, 15);
    SPI_MOSI = d[0]; repeat (4) tick(); SPI_CLK = 1;
    repeat (2) tick(); OutReady = 1; tick(); OutReady = 0;
    expectWord(d, r);
    tick(); SPI_CLK = 0; csHigh(); tests++;
    if (Overflow !== expOverflow) begin fails++; $display("FAIL coincide_ovf got %b expected %b", Overflow, expOverflow); end
    drain("coincide");
  endtask

  task test_frame_err;
    int pulses;
    OutReady = 1; csLow(); RS = 1;
    shiftBits(16'($urandom), 7);
    SPI_CS = 1; pulses = 0;
    repeat (10) begin tick(); pulses += int'(FrameErr); end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL frame_err_pulse got %0d cycles expected 1", pulses); end
    tests++;
    if (OutValid !== 0) begin fails++; $display("FAIL frame_err_nopush got valid=%b expected 0", OutValid); end
    csLow(); sendWord(16'h1234, 1); csHigh(); drain("frame_err");
  endtask

  task test_reset_midword;
    OutReady = 0; csLow(); sendWord(16'h5555, 1);
    RS = 0; shiftBits(16'($urandom), 8);
    nRST = 0; #1 checkZero("reset_midword");
    q.delete(); expOverflow = 0; accepted = 0;
    repeat (3) tick(); nRST = 1; OutReady = 1;
    shiftBits(16'($urandom), 8); shiftBits(16'($urandom), 16);
    repeat (4) tick(); tests++;
    if (OutValid !== 0) begin fails++; $display("FAIL stale_frame got valid=%b expected 0", OutValid); end
    csHigh(); csLow(); sendWord(16'hBEEF, 1); csHigh(); drain("beef");
`ifdef TFT_SPI_RX_STATUS_EN
    tests++;
    if (WordCount !== 16'(accepted)) begin fails++; $display("FAIL word_count got %0d expected %0d", WordCount, accepted); end
`endif
  endtask

  task test_random;
    randDone = 0;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          csLow();
          for (int w = $urandom_range(1, 3); w > 0; w--) sendWord(16'($urandom), 1'($urandom));
          csHigh();
        end
        randDone = 1;
      end
      begin
        while (!randDone) begin OutReady = 1'($urandom_range(0, 1)); tick(); end
      end
    join
    drain("random"); tests++;
    if (Overflow !== expOverflow) begin fails++; $display("FAIL random_ovf got %b expected %b", Overflow, expOverflow); end
`ifdef TFT_SPI_RX_STATUS_EN
    tests++;
    if (WordCount !== 16'(accepted)) begin fails++; $display("FAIL random_count got %0d expected %0d", WordCount, accepted); end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_coincide();
    test_frame_err();
    test_reset_midword();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
